udp_box_receiver: RTL and testbench

UDP_BOX_RECEIVER -- requirements
Module: udp_box_receiver

---
 rtl/udp_box_receiver_if.sv | 31 +++
 rtl/udp_box_receiver.sv | 111 +++++++++++
 tb/tb_udp_box_receiver.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_box_receiver_if.sv
// rtl/udp_box_receiver_if.sv - byte-stream in / box-data out bundle for udp_box_receiver
//
// Purpose: groups the rx payload stream and the parser-facing result signals.
// Signals:
//   valid   - rx payload byte strobe, high for the whole packet, low between packets
//   i_data  - rx payload byte, qualified by valid
//   i_len   - UDP payload length of the current packet, stable while valid is high
//   o_data  - last committed box data (N_BOX*48 bits, first payload byte in the MSBs)
//   update  - one-cycle pulse when o_data is committed
//   err     - one-cycle pulse when a packet is rejected
// Modports: master drives the stream (rx side), slave is the receiver.
interface udp_box_receiver_if #(
  parameter int N_BOX = 1
) ();
  logic                 valid;
  logic [7:0]           i_data;
  logic [15:0]          i_len;
  logic [N_BOX*48-1:0]  o_data;
  logic                 update;
  logic                 err;

  modport master (
    output valid, i_data, i_len,
    input  o_data, update, err
  );

  modport slave (
    input  valid, i_data, i_len,
    output o_data, update, err
  );
endinterface

// File: rtl/udp_box_receiver.sv
// rtl/udp_box_receiver.sv - validates UDP draw-box command packets and commits their payload
//
// Purpose: watches the rx payload byte stream, checks the leading MAGIC byte and
// the UDP length, collects N_BOX*6 box bytes into a shadow register and, when the
// packet ends with exactly the expected byte count, commits them to o_data.
// Any malformed packet (bad magic, wrong length field, short, overlong) raises err.
// Ports:
//   clk - rx byte clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - udp_box_receiver_if.slave (valid, i_data, i_len in; o_data, update, err out)
// Optional feature: define BOX_RX_CHECKSUM_EN to require a trailing XOR checksum
// byte (XOR of every preceding byte, MAGIC included); it never enters o_data.
module udp_box_receiver #(
  parameter int         N_BOX = 1,
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input logic               clk,
  input logic               rst,
  udp_box_receiver_if.slave bus
);
  localparam int DATA_W     = 48 * N_BOX;
  localparam int DATA_BYTES = 6 * N_BOX;
`ifdef BOX_RX_CHECKSUM_EN
  localparam int EXP = 2 + DATA_BYTES;
`else
  localparam int EXP = 1 + DATA_BYTES;
`endif
  localparam int               CNT_W     = $clog2(EXP + 1);
  localparam logic [CNT_W-1:0] EXP_CNT   = CNT_W'(EXP);
  // Counter value of the last box byte; anything after it is the checksum byte.
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BYTES);

  typedef enum logic [1:0] {SYNC, IDLE, PAYLOAD, DRAIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shadow;
  logic              frame_ok;

`ifdef BOX_RX_CHECKSUM_EN
  // Running XOR over every byte including the checksum: a good packet folds to zero.
  logic [7:0] csum;
  assign frame_ok = (cnt == EXP_CNT) && (csum == 8'h00);
`else
  assign frame_ok = (cnt == EXP_CNT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      cnt        <= '0;
      shadow     <= '0;
      bus.o_data <= '0;
      bus.update <= 1'b0;
      bus.err    <= 1'b0;
`ifdef BOX_RX_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      bus.update <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        // Reset may land mid-packet: wait for a gap so the tail is silently dropped.
        SYNC: begin
          if (!bus.valid) state <= IDLE;
        end
        IDLE: begin
          if (bus.valid) begin
            if (bus.i_data == MAGIC && bus.i_len == 16'(EXP)) begin
              state <= PAYLOAD;
              cnt   <= CNT_W'(1);  // MAGIC counts as the first byte
`ifdef BOX_RX_CHECKSUM_EN
              csum  <= bus.i_data;
`endif
            end else begin
              state <= DRAIN;
            end
          end
        end
        PAYLOAD: begin
          if (bus.valid) begin
            if (cnt == EXP_CNT) begin
              state <= DRAIN;  // overlong
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt <= LAST_DATA) shadow <= {shadow[DATA_W-9:0], bus.i_data};
`ifdef BOX_RX_CHECKSUM_EN
              csum <= csum ^ bus.i_data;
`endif
            end
          end else begin
            state <= IDLE;
            if (frame_ok) begin
              bus.o_data <= shadow;
              bus.update <= 1'b1;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!bus.valid) begin
            state   <= IDLE;
            bus.err <= 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_box_receiver.sv
// tb/tb_udp_box_receiver.sv - self-checking bench for udp_box_receiver
module tb_udp_box_receiver;
  localparam int         N_BOX = 1;
  localparam logic [7:0] MAGIC = 8'hA5;
  localparam int         DW    = 48 * N_BOX;
  localparam int         DB    = 6 * N_BOX;
`ifdef BOX_RX_CHECKSUM_EN
  localparam int         EXP   = DB + 2;
`else
  localparam int         EXP   = DB + 1;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_box_receiver_if #(.N_BOX(N_BOX)) bus ();

  udp_box_receiver #(.N_BOX(N_BOX), .MAGIC(MAGIC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int upd_seen = 0;
  int err_seen = 0;
  int both_seen = 0;
  int upd_exp  = 0;
  int err_exp  = 0;
  logic [DW-1:0] model_odata = '0;

  always @(negedge clk) begin
    if (bus.update === 1'b1) upd_seen++;
    if (bus.err === 1'b1) err_seen++;
    if (bus.update === 1'b1 && bus.err === 1'b1) both_seen++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a packet is good when it has exactly EXP bytes, the length field
  // says EXP, it starts with MAGIC and (with checksum) all bytes XOR to zero.
  function automatic logic ref_ok(input bq_t pkt, input logic [15:0] len);
    logic ok;
    logic [7:0] x;
    ok = (pkt.size() == EXP) && (len == 16'(EXP)) && (pkt[0] == MAGIC);
`ifdef BOX_RX_CHECKSUM_EN
    x = 8'h00;
    foreach (pkt[i]) x = x ^ pkt[i];
    ok = ok && (x == 8'h00);
`else
    x = 8'h00;
`endif
    return ok;
  endfunction

  function automatic logic [DW-1:0] ref_payload(input bq_t pkt);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DB; i++) d[DW-1-8*i -: 8] = pkt[i+1];
    return d;
  endfunction

  function automatic bq_t make_good(input logic [DW-1:0] payload);
    bq_t q;
    logic [7:0] x;
    q.push_back(MAGIC);
    for (int i = 0; i < DB; i++) q.push_back(payload[DW-1-8*i -: 8]);
`ifdef BOX_RX_CHECKSUM_EN
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`else
    x = 8'h00;
`endif
    return q;
  endfunction

  function automatic logic [DW-1:0] rand_payload();
    logic [DW-1:0] d;
    for (int i = 0; i < DB; i++) d[8*i +: 8] = 8'($urandom);
    return d;
  endfunction

  // Called on a falling edge; returns on the falling edge where the result is visible.
  task automatic send_bytes(input bq_t pkt, input logic [15:0] len);
    foreach (pkt[i]) begin
      bus.valid  = 1'b1;
      bus.i_data = pkt[i];
      bus.i_len  = len;
      @(negedge clk);
    end
    bus.valid  = 1'b0;
    bus.i_data = 8'h00;
    @(negedge clk);
  endtask

  task automatic expect_result(input bq_t pkt, input logic [15:0] len, input string tag);
    logic ok;
    ok = ref_ok(pkt, len);
    if (ok) begin
      model_odata = ref_payload(pkt);
      upd_exp++;
    end else begin
      err_exp++;
    end
    chk({tag, ".update"}, DW'(bus.update), DW'(ok));
    chk({tag, ".err"}, DW'(bus.err), DW'(!ok));
    chk({tag, ".o_data"}, bus.o_data, model_odata);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    chk({tag, ".update_off"}, DW'(bus.update), '0);
    chk({tag, ".err_off"}, DW'(bus.err), '0);
  endtask

  task automatic run_pkt(input bq_t pkt, input logic [15:0] len, input string tag);
    send_bytes(pkt, len);
    expect_result(pkt, len, tag);
    check_quiet(tag);
  endtask

  initial begin
    bq_t p;
    bq_t p2;
    logic [15:0] len;
    int kind;
    int n;

    rst        = 1'b1;
    bus.valid  = 1'b0;
    bus.i_data = 8'h00;
    bus.i_len  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset.o_data", bus.o_data, '0);
    chk("reset.update", DW'(bus.update), '0);
    chk("reset.err", DW'(bus.err), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reference packet A5 01 02 03 04 05 06 (+ checksum when compiled in)
    p = make_good(48'h010203040506);
    run_pkt(p, 16'(EXP), "good_ref");
    chk("good_ref.value", bus.o_data, 48'h010203040506);

`ifdef BOX_RX_CHECKSUM_EN
    p = make_good(48'h010203040506);
    chk("csum_byte", DW'(p[EXP-1]), DW'(8'hA2));
    p[EXP-1] = 8'h00;
    run_pkt(p, 16'(EXP), "csum_bad");
    chk("csum_bad.hold", bus.o_data, 48'h010203040506);
`endif

    p = make_good(48'h010203040506);
    p[0] = 8'h5A;
    run_pkt(p, 16'(EXP), "bad_magic");

    p = make_good(48'h010203040506);
    void'(p.pop_back());
    run_pkt(p, 16'(EXP), "short");

    p = make_good(48'h010203040506);
    p.push_back(8'h07);
    run_pkt(p, 16'(EXP), "long");
    chk("long.hold", bus.o_data, 48'h010203040506);

    p = make_good(48'h0A0B0C0D0E0F);
    run_pkt(p, 16'(EXP + 1), "bad_len");

    // Reset after the third byte; the tail of that packet must stay silent.
    p = make_good(rand_payload());
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1; bus.i_data = p[i]; bus.i_len = 16'(EXP);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midrst.o_data", bus.o_data, '0);
    model_odata = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i < p.size(); i++) begin
      bus.valid = 1'b1; bus.i_data = p[i]; bus.i_len = 16'(EXP);
      @(negedge clk);
    end
    bus.valid = 1'b0;
    @(negedge clk);
    chk("midrst.update", DW'(bus.update), '0);
    chk("midrst.err", DW'(bus.err), '0);
    chk("midrst.hold", bus.o_data, '0);
    check_quiet("midrst");
    p = make_good(rand_payload());
    run_pkt(p, 16'(EXP), "after_rst");

    // Two good packets with only a one-cycle gap.
    p  = make_good(rand_payload());
    p2 = make_good(rand_payload());
    send_bytes(p, 16'(EXP));
    expect_result(p, 16'(EXP), "b2b_1");
    send_bytes(p2, 16'(EXP));
    expect_result(p2, 16'(EXP), "b2b_2");
    check_quiet("b2b_2");

    for (int k = 0; k < 40; k++) begin
      p = make_good(rand_payload());
      len = 16'(EXP);
      kind = $urandom_range(0, 6);
      case (kind)
        2: p[0] = p[0] ^ 8'(1 << $urandom_range(0, 7));
        3: begin
          n = $urandom_range(1, EXP - 1);
          while (p.size() > n) void'(p.pop_back());
        end
        4: repeat ($urandom_range(1, 3)) p.push_back(8'($urandom));
        5: len = len + 16'($urandom_range(1, 5));
`ifdef BOX_RX_CHECKSUM_EN
        6: p[EXP-1] = p[EXP-1] ^ 8'(1 << $urandom_range(0, 7));
`endif
        default: ;
      endcase
      run_pkt(p, len, $sformatf("rand%0d_k%0d", k, kind));
    end

    chk("total_updates", DW'(upd_seen), DW'(upd_exp));
    chk("total_errs", DW'(err_seen), DW'(err_exp));
    chk("never_both", DW'(both_seen), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
